// File: rtl/ssdma_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: state encodings and
// default sizing constants.
package ssdma_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_KILL  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_M   = 5;
    localparam int DEF_IDW     = 3;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational rotate-priority picker: returns the first requester found
// searching upward from last+1, wrapping explicitly at NUM_M-1.
module wb_arb_rr_pick
    import ssdma_arb_pkg::*;
#(
    parameter int NUM_M = DEF_NUM_M,
    parameter int IDW   = DEF_IDW
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDW-1:0]   last_i,
    output logic             any_o,
    output logic [IDW-1:0]   win_id_o,
    output logic [NUM_M-1:0] win_oh_o
);

    always_comb begin
        int start;
        int idx;
        logic [NUM_M-1:0] sh;
        any_o    = 1'b0;
        win_id_o = '0;
        win_oh_o = '0;
        idx      = 0;
        sh       = '0;
        // NUM_M need not be a power of two, so the wrap cannot rely on overflow.
        start = (int'(last_i) >= NUM_M - 1) ? 0 : int'(last_i) + 1;
        for (int i = 0; i < NUM_M; i++) begin
            idx = start + i;
            if (idx >= NUM_M) idx = idx - NUM_M;
            sh = req_i >> idx;
            if (!any_o && sh[0]) begin
                any_o    = 1'b1;
                win_id_o = IDW'(idx);
                win_oh_o = NUM_M'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arb.sv
// Round-robin arbiter for the shared SG-memory Wishbone port. Grant is locked for
// the owner's whole cyc tenure; optional watchdog enabled by `define WB_ARB_WDOG_EN.
module wb_rr_arb
    import ssdma_arb_pkg::*;
#(
    parameter int NUM_M   = DEF_NUM_M,
    parameter int IDW     = DEF_IDW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NUM_M-1:0] wbs_cyc_i,
    input  logic             wbm_ack_i,
    input  logic             wbm_err_i,
    output logic [NUM_M-1:0] gnt,
    output logic             gnt_vld,
    output logic [IDW-1:0]   gnt_id,
    output logic             arb_timeout_o
);

    arb_state_e       state_q;
    logic [NUM_M-1:0] gnt_q;
    logic             gnt_vld_q;
    logic [IDW-1:0]   gnt_id_q;
    logic [IDW-1:0]   last_q;
    logic             timeout_q;
    logic [NUM_M-1:0] kill_mask_q;

    logic [NUM_M-1:0] elig_d;
    logic             owner_cyc_d;
    logic             pick_any;
    logic [IDW-1:0]   pick_id;
    logic [NUM_M-1:0] pick_oh;
    logic             wdog_hit_d;

    assign elig_d      = wbs_cyc_i & ~kill_mask_q;
    assign owner_cyc_d = |(wbs_cyc_i & gnt_q);

    wb_arb_rr_pick #(
        .NUM_M (NUM_M),
        .IDW   (IDW)
    ) u_pick (
        .req_i    (elig_d),
        .last_i   (last_q),
        .any_o    (pick_any),
        .win_id_o (pick_id),
        .win_oh_o (pick_oh)
    );

`ifdef WB_ARB_WDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wdog_cnt_q;
    logic           slave_resp_d;

    assign slave_resp_d = wbm_ack_i | wbm_err_i;
    // A response in the limit cycle rescues the owner.
    assign wdog_hit_d = (state_q == ARB_GRANT) && owner_cyc_d && !slave_resp_d &&
                        (wdog_cnt_q == WDW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wdog_cnt_q <= '0;
        end else if (state_q == ARB_IDLE && pick_any) begin
            wdog_cnt_q <= '0;
        end else if (state_q == ARB_GRANT) begin
            wdog_cnt_q <= (slave_resp_d || wdog_hit_d) ? '0 : wdog_cnt_q + WDW'(1);
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^{wbm_ack_i, wbm_err_i, 32'(TIMEOUT)};
    assign wdog_hit_d  = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= '0;
            gnt_vld_q   <= 1'b0;
            gnt_id_q    <= '0;
            last_q      <= IDW'(NUM_M - 1);
            timeout_q   <= 1'b0;
            kill_mask_q <= '0;
        end else begin
            timeout_q   <= 1'b0;
            kill_mask_q <= kill_mask_q & wbs_cyc_i;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_q   <= ARB_GRANT;
                        gnt_q     <= pick_oh;
                        gnt_vld_q <= 1'b1;
                        gnt_id_q  <= pick_id;
                        last_q    <= pick_id;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_cyc_d) begin
                        state_q   <= ARB_IDLE;
                        gnt_q     <= '0;
                        gnt_vld_q <= 1'b0;
                    end else if (wdog_hit_d) begin
                        state_q     <= ARB_KILL;
                        gnt_q       <= '0;
                        gnt_vld_q   <= 1'b0;
                        timeout_q   <= 1'b1;
                        kill_mask_q <= (kill_mask_q & wbs_cyc_i) | gnt_q;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign gnt           = gnt_q;
    assign gnt_vld       = gnt_vld_q;
    assign gnt_id        = gnt_id_q;
    assign arb_timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arb.sv
// Self-checking bench for wb_rr_arb: directed vector table, hand sequences for the
// watchdog and reset corners, and randomized traffic against a behavioural model.
module tb_wb_rr_arb;

    localparam int NUM_M = 5;
    localparam int IDW   = 3;
`ifdef WB_ARB_WDOG_EN
    localparam int TO   = 8;
    localparam bit WDOG = 1'b1;
`else
    localparam int TO   = 1024;
    localparam bit WDOG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NUM_M-1:0] cyc = '0;
    logic             ack = 1'b0;
    logic             err = 1'b0;
    logic [NUM_M-1:0] gnt;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_id;
    logic             arb_to;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_rr_arb #(.NUM_M(NUM_M), .IDW(IDW), .TIMEOUT(TO)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbm_ack_i     (ack),
        .wbm_err_i     (err),
        .gnt           (gnt),
        .gnt_vld       (gnt_vld),
        .gnt_id        (gnt_id),
        .arb_timeout_o (arb_to)
    );

    // Behavioural reference: owner index (-1 = none), rotating pointer, blocked set.
    int       m_owner;
    int       m_last;
    int       m_id;
    int       m_age;
    bit       m_kill_st;
    bit       m_to;
    bit [4:0] m_blk;

    function automatic void model_reset();
        m_owner   = -1;
        m_last    = NUM_M - 1;
        m_id      = 0;
        m_age     = 0;
        m_kill_st = 1'b0;
        m_to      = 1'b0;
        m_blk     = '0;
    endfunction

    function automatic void model_step(logic [4:0] c, logic a, logic e);
        bit [4:0] old_blk;
        int w;
        old_blk = m_blk;
        m_to = 1'b0;
        for (int k = 0; k < NUM_M; k++) if (!c[k]) m_blk[k] = 1'b0;
        if (m_kill_st) begin
            m_kill_st = 1'b0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int k = 1; k <= NUM_M; k++) begin
                int cand;
                cand = (m_last + k) % NUM_M;
                if (w < 0 && c[cand] && !old_blk[cand]) w = cand;
            end
            if (w >= 0) begin
                m_owner = w;
                m_id    = w;
                m_last  = w;
                m_age   = 0;
            end
        end else if (!c[m_owner]) begin
            m_owner = -1;
        end else if (WDOG && !(a || e) && m_age == TO - 1) begin
            m_blk[m_owner] = 1'b1;
            m_owner   = -1;
            m_kill_st = 1'b1;
            m_to      = 1'b1;
        end else begin
            m_age = (a || e) ? 0 : m_age + 1;
        end
    endfunction

    function automatic logic [4:0] model_gnt();
        logic [4:0] one;
        one = 5'd1;
        return (m_owner >= 0) ? (one << m_owner) : 5'd0;
    endfunction

    task automatic check(string name, logic [4:0] eg, logic [2:0] eid, logic eto);
        n_checks++;
        if (gnt !== eg || gnt_vld !== (|eg) || gnt_id !== eid || arb_to !== eto) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b vld=%b id=%0d to=%b, expected gnt=%b vld=%b id=%0d to=%b",
                     name, gnt, gnt_vld, gnt_id, arb_to, eg, |eg, eid, eto);
        end
    endtask

    task automatic drive(logic [4:0] c, logic a, logic e);
        cyc = c;
        ack = a;
        err = e;
        @(posedge clk);
        model_step(c, a, e);
        #1;
        check("model", model_gnt(), 3'(m_id), m_to);
    endtask

    task automatic do_reset(logic [4:0] c);
        rst = 1'b1;
        cyc = c;
        ack = 1'b0;
        err = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        check("reset", 5'd0, 3'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic expect_step(string name, logic [4:0] c, logic a, logic [4:0] eg,
                               logic [2:0] eid, logic eto);
        drive(c, a, 1'b0);
        check(name, eg, eid, eto);
    endtask

    typedef struct {
        logic [4:0] cyc;
        logic       ack;
        logic [4:0] gnt;
        logic [2:0] id;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic [4:0] c, logic [4:0] g, logic [2:0] id);
        vec_t v;
        v.cyc = c; v.ack = 1'b0; v.gnt = g; v.id = id; v.to = 1'b0;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [4:0] rc;
        logic [4:0] one;
        one = 5'd1;

        // Single master, then mid-tenure arrivals, then same-cycle drop/rise.
        add(5'b00001, 5'b00001, 3'd0);
        add(5'b00001, 5'b00001, 3'd0);
        add(5'b00000, 5'b00000, 3'd0);
        add(5'b00000, 5'b00000, 3'd0);
        add(5'b00100, 5'b00100, 3'd2);
        add(5'b10101, 5'b00100, 3'd2);
        add(5'b10101, 5'b00100, 3'd2);
        add(5'b10001, 5'b00000, 3'd2);
        add(5'b10001, 5'b10000, 3'd4);
        add(5'b00001, 5'b00000, 3'd4);
        add(5'b00001, 5'b00001, 3'd0);
        add(5'b00010, 5'b00000, 3'd0);
        add(5'b00010, 5'b00010, 3'd1);
        add(5'b00000, 5'b00000, 3'd1);
        add(5'b00000, 5'b00000, 3'd1);

        model_reset();
        do_reset(5'b00000);
        for (int i = 0; i < tbl.size(); i++)
            expect_step($sformatf("vec%0d", i), tbl[i].cyc, tbl[i].ack,
                        tbl[i].gnt, tbl[i].id, tbl[i].to);

        // All requesting: order 0,1,2,3,4,0 with a one-cycle gap per handover.
        do_reset(5'b00000);
        for (int t = 0; t < 6; t++) begin
            int w;
            w = t % NUM_M;
            for (int k = 0; k < 4; k++)
                expect_step($sformatf("rr_t%0d", t), 5'b11111, 1'b0, one << w, 3'(w), 1'b0);
            expect_step($sformatf("rr_gap%0d", t), 5'b11111 & ~(one << w), 1'b0,
                        5'd0, 3'(w), 1'b0);
        end
        expect_step("rr_next", 5'b11111, 1'b0, 5'b00010, 3'd1, 1'b0);
        expect_step("rr_hold", 5'b11111, 1'b0, 5'b00010, 3'd1, 1'b0);

        // Reset mid-tenure, then master 0 wins first.
        do_reset(5'b11111);
        expect_step("post_rst", 5'b11111, 1'b0, 5'b00001, 3'd0, 1'b0);

`ifdef WB_ARB_WDOG_EN
        do_reset(5'b00000);
        expect_step("wd_grant", 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b0);
        for (int i = 0; i < 7; i++)
            expect_step("wd_hold", 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b0);
        expect_step("wd_kill", 5'b01000, 1'b0, 5'b00000, 3'd3, 1'b1);
        expect_step("wd_after", 5'b01000, 1'b0, 5'b00000, 3'd3, 1'b0);
        expect_step("wd_block1", 5'b01000, 1'b0, 5'b00000, 3'd3, 1'b0);
        expect_step("wd_block2", 5'b01000, 1'b0, 5'b00000, 3'd3, 1'b0);
        expect_step("wd_low", 5'b00000, 1'b0, 5'b00000, 3'd3, 1'b0);
        expect_step("wd_regrant", 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b0);
        for (int i = 0; i < 30; i++)
            expect_step("wd_ack5", 5'b01000, 1'(i % 5 == 4), 5'b01000, 3'd3, 1'b0);
        for (int i = 0; i < 7; i++)
            expect_step("wd_count", 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b0);
        expect_step("wd_ack_wins", 5'b01000, 1'b1, 5'b01000, 3'd3, 1'b0);
        for (int i = 0; i < 7; i++)
            expect_step("wd_count2", 5'b01000, 1'b0, 5'b01000, 3'd3, 1'b0);
        expect_step("wd_kill2", 5'b01000, 1'b0, 5'b00000, 3'd3, 1'b1);
        expect_step("wd_drop", 5'b00000, 1'b0, 5'b00000, 3'd3, 1'b0);
`else
        // Without the watchdog a silent owner keeps the grant indefinitely.
        do_reset(5'b00000);
        expect_step("hold_grant", 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b0);
        for (int i = 0; i < 1100; i++)
            expect_step("hold_long", 5'b00001, 1'b0, 5'b00001, 3'd0, 1'b0);
`endif

        // Randomized traffic checked only against the behavioural model.
        do_reset(5'b00000);
        rc = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (rc[k]) begin
                    if ($urandom_range(0, 5) == 0) rc[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rc[k] = 1'b1;
                end
            end
            drive(rc, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            if (i == 1500) do_reset(rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
